tdma_dispatcher: RTL and testbench

TDMA_DISPATCHER -- requirements
Module: tdma_dispatcher

---
 rtl/tdma_dispatcher_pkg.sv | 17 +
 rtl/tdma_dispatcher_fifo.sv | 55 +++++
 rtl/tdma_dispatcher.sv | 93 +++++++++
 tb/tb_tdma_dispatcher.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tdma_dispatcher_pkg.sv
// Shared TDMA constants and the port-id width helper used by the dispatcher and the scheduler.
package tdma_pkg;

  localparam int unsigned TDMA_NB_PORTS   = 4;
  localparam int unsigned TDMA_DATA_WIDTH = 32;
  localparam int unsigned TDMA_FIFO_DEPTH = 4;

  // Port ids are at least one bit wide so a 1-port corner still elaborates.
  function automatic int unsigned tdma_id_width(input int unsigned nb_ports);
    return (nb_ports > 1) ? $clog2(nb_ports) : 1;
  endfunction

  localparam int unsigned TDMA_ID_W = tdma_id_width(TDMA_NB_PORTS);

  typedef logic [TDMA_ID_W-1:0] tdma_port_id_t;

endpackage

// File: rtl/tdma_dispatcher_fifo.sv
// Per-port circular buffer: push refused when full, pop ignored when empty, head word exposed.
module tdma_fifo
  import tdma_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = TDMA_DATA_WIDTH,
  parameter int unsigned DEPTH      = TDMA_FIFO_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  i_push,
  input  logic                  i_pop,
  input  logic [DATA_WIDTH-1:0] i_data,
  output logic                  o_full,
  output logic                  o_empty,
  output logic [DATA_WIDTH-1:0] o_head
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned CW = PW + 1;

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]         r_wptr;
  logic [PW-1:0]         r_rptr;
  logic [CW-1:0]         r_count;
  logic                  w_do_push;
  logic                  w_do_pop;

  assign o_full    = (r_count == CW'(DEPTH));
  assign o_empty   = (r_count == '0);
  assign o_head    = r_mem[r_rptr];
  assign w_do_push = i_push && !o_full;
  assign w_do_pop  = i_pop && !o_empty;

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_do_push) r_wptr <= r_wptr + PW'(1);
      if (w_do_pop)  r_rptr <= r_rptr + PW'(1);
      case ({w_do_push, w_do_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wptr] <= i_data;
  end

endmodule

// File: rtl/tdma_dispatcher.sv
// TDMA dispatcher: per-port FIFOs drained one word per cycle from the slot owner into a registered output stage.
module tdma_dispatcher
  import tdma_pkg::*;
#(
  parameter  int unsigned NB_PORTS   = TDMA_NB_PORTS,
  parameter  int unsigned DATA_WIDTH = TDMA_DATA_WIDTH,
  parameter  int unsigned FIFO_DEPTH = TDMA_FIFO_DEPTH,
  localparam int unsigned ID_W       = tdma_id_width(NB_PORTS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NB_PORTS-1:0]   in_valid,
  output logic [NB_PORTS-1:0]   in_ready,
  input  logic [DATA_WIDTH-1:0] in_data [NB_PORTS],
  input  logic [ID_W-1:0]       selection,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [ID_W-1:0]       out_id
);

  logic [NB_PORTS-1:0]   w_full;
  logic [NB_PORTS-1:0]   w_empty;
  logic [NB_PORTS-1:0]   w_push;
  logic [NB_PORTS-1:0]   w_pop;
  logic [DATA_WIDTH-1:0] w_head [NB_PORTS];
  logic                  w_sel_avail;
  logic [DATA_WIDTH-1:0] w_sel_data;
  logic                  w_load;

  logic                  r_out_valid;
  logic [DATA_WIDTH-1:0] r_out_data;
  logic [ID_W-1:0]       r_out_id;

  assign in_ready = ~w_full;
  assign w_push   = in_valid & in_ready;

  // An out-of-range selection matches no port, so it never loads nor pops.
  always_comb begin
    w_sel_avail = 1'b0;
    w_sel_data  = '0;
    for (int unsigned p = 0; p < NB_PORTS; p++) begin
      if (selection == ID_W'(p) && !w_empty[p]) begin
        w_sel_avail = 1'b1;
        w_sel_data  = w_head[p];
      end
    end
  end

  assign w_load = (!r_out_valid || out_ready) && w_sel_avail;

  always_comb begin
    w_pop = '0;
    for (int unsigned p = 0; p < NB_PORTS; p++) begin
      w_pop[p] = w_load && (selection == ID_W'(p));
    end
  end

  for (genvar g = 0; g < NB_PORTS; g++) begin : g_port
    tdma_fifo #(
      .DATA_WIDTH(DATA_WIDTH),
      .DEPTH     (FIFO_DEPTH)
    ) u_fifo (
      .clk    (clk),
      .rst_n  (rst_n),
      .i_push (w_push[g]),
      .i_pop  (w_pop[g]),
      .i_data (in_data[g]),
      .o_full (w_full[g]),
      .o_empty(w_empty[g]),
      .o_head (w_head[g])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_id    <= '0;
    end else if (w_load) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_sel_data;
      r_out_id    <= selection;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_id    = r_out_id;

endmodule

// File: tb/tb_tdma_dispatcher.sv
// Directed bench for tdma_dispatcher with a per-port order scoreboard fed from observed handshakes.
module tb_tdma_dispatcher;

  localparam int unsigned NB = 4;
  localparam int unsigned DW = 32;
  localparam int unsigned FD = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [NB-1:0] in_valid = '0;
  logic [NB-1:0] in_ready;
  logic [DW-1:0] in_data [NB];
  logic [1:0]    selection = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [1:0]    out_id;

  always #5 clk = ~clk;

  tdma_dispatcher #(
    .NB_PORTS  (NB),
    .DATA_WIDTH(DW),
    .FIFO_DEPTH(FD)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .in_data  (in_data),
    .selection(selection),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data (out_data),
    .out_id   (out_id)
  );

  int unsigned   n_checks = 0;
  int unsigned   n_pass   = 0;
  logic [DW-1:0] exp_q [NB][$];
  int unsigned   slot_len [NB] = '{4, 8, 16, 32};
  bit            sched_mode = 1'b0;
  bit            run_started = 1'b0;
  bit            run_first = 1'b0;
  logic [1:0]    run_id = '0;
  int unsigned   run_len = 0;
  int unsigned   bursts_checked = 0;
  int unsigned   seq [NB];

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_true(input string tag, input bit cond);
    n_checks++;
    assert (cond) n_pass++;
    else $error("FAIL %s: observed 0 expected 1", tag);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_feed();
    logic [NB-1:0] acc;
    acc = in_valid & in_ready;
    tick();
    for (int p = 0; p < NB; p++) begin
      if (acc[p]) begin
        seq[p]++;
        in_data[p] = {8'(p), 8'h5A, 16'(seq[p])};
      end
    end
  endtask

  function automatic bit all_empty();
    for (int p = 0; p < NB; p++) if (exp_q[p].size() != 0) return 1'b0;
    return 1'b1;
  endfunction

  // Scoreboard: record accepted pushes, pop and compare on every output handshake.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    if (!rst_n) begin
      for (int p = 0; p < NB; p++) exp_q[p].delete();
      run_started = 1'b0;
    end else begin
      if (out_valid && out_ready) begin
        check_true("word_expected", exp_q[out_id].size() != 0);
        if (exp_q[out_id].size() != 0) begin
          e = exp_q[out_id].pop_front();
          check("order_data", {32'b0, out_data}, {32'b0, e});
        end
        if (!sched_mode) begin
          run_started = 1'b0;
        end else if (run_started && out_id == run_id) begin
          run_len++;
        end else begin
          if (run_started && !run_first) begin
            check_true("burst_len", run_len <= slot_len[run_id] && run_len + 1 >= slot_len[run_id]);
            bursts_checked++;
          end
          run_first   = !run_started;
          run_started = 1'b1;
          run_id      = out_id;
          run_len     = 1;
        end
      end
      for (int p = 0; p < NB; p++)
        if (in_valid[p] && in_ready[p]) exp_q[p].push_back(in_data[p]);
    end
  end

  initial begin
    #200000;
    $error("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "bench did not complete");
  end

  initial begin
    for (int p = 0; p < NB; p++) begin
      in_data[p] = '0;
      seq[p]     = 0;
    end

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_id", out_id, 0);
    rst_n = 1'b1;
    tick();
    check("rst_in_ready", in_ready, 4'hF);

    // Single word latency
    selection = 2'd0; out_ready = 1'b1;
    in_valid = 4'b0001; in_data[0] = 32'hA0;
    tick();
    in_valid = '0;
    check("lat_not_yet", out_valid, 0);
    tick();
    check("lat_valid", out_valid, 1);
    check("lat_data", out_data, 32'hA0);
    check("lat_id", out_id, 0);
    tick();
    check("lat_drop", out_valid, 0);

    // Fill port 2 while another port owns the slot, then drain it
    selection = 2'd1;
    for (int i = 0; i < 4; i++) begin
      in_valid = 4'b0100; in_data[2] = 32'hB0 + 32'(i);
      tick();
    end
    in_valid = '0;
    check("p2_full", in_ready[2], 0);
    check("p2_no_out", out_valid, 0);
    tick();
    check("p2_no_out2", out_valid, 0);
    selection = 2'd2;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("p2_valid", out_valid, 1);
      check("p2_data", out_data, 32'hB0 + 32'(i));
      check("p2_id", out_id, 2);
    end
    check("p2_ready_again", in_ready[2], 1);
    tick();
    check("p2_idle", out_valid, 0);

    // Stall holds output across a selection change
    selection = 2'd0; out_ready = 1'b0;
    in_valid = 4'b1001; in_data[0] = 32'hC0; in_data[3] = 32'hD0;
    tick();
    in_valid = 4'b1000; in_data[3] = 32'hD1;
    tick();
    in_valid = '0;
    check("stall_valid", out_valid, 1);
    check("stall_data", out_data, 32'hC0);
    check("stall_id", out_id, 0);
    selection = 2'd3;
    repeat (3) begin
      tick();
      check("stall_hold_valid", out_valid, 1);
      check("stall_hold_data", out_data, 32'hC0);
      check("stall_hold_id", out_id, 0);
    end
    out_ready = 1'b1;
    tick();
    check("stall_next_data", out_data, 32'hD0);
    check("stall_next_id", out_id, 3);
    tick();
    check("stall_next2_data", out_data, 32'hD1);
    tick();
    check("stall_idle", out_valid, 0);

    // Full port refuses a push even when popped in the same cycle
    selection = 2'd2;
    for (int i = 0; i < 4; i++) begin
      in_valid = 4'b0010; in_data[1] = 32'hE0 + 32'(i);
      tick();
    end
    check("p1_full", in_ready[1], 0);
    in_data[1] = 32'hE4;
    selection = 2'd1;
    tick();
    check("p1_refused_ready", in_ready[1], 1);
    check("p1_pop0", out_data, 32'hE0);
    check("p1_pop0_id", out_id, 1);
    tick();
    check("p1_pushpop_ready", in_ready[1], 1);
    check("p1_pop1", out_data, 32'hE1);
    in_data[1] = 32'hE5;
    selection = 2'd2;
    tick();
    check("p1_full_again", in_ready[1], 0);
    check("p1_gap", out_valid, 0);
    in_valid = '0;
    selection = 2'd1;
    for (int i = 0; i < 4; i++) begin
      tick();
      check("p1_drain", out_data, 32'hE2 + 32'(i));
    end
    tick();
    check("p1_idle", out_valid, 0);

    // TDMA schedule with every port continuously fed
    for (int p = 0; p < NB; p++) in_data[p] = {8'(p), 8'h5A, 16'(seq[p])};
    in_valid = '1; out_ready = 1'b1; sched_mode = 1'b1;
    for (int r = 0; r < 2; r++) begin
      for (int p = 0; p < NB; p++) begin
        selection = 2'(p);
        repeat (slot_len[p]) tick_feed();
      end
    end
    sched_mode = 1'b0;
    in_valid = '0;
    begin
      int unsigned guard = 0;
      while (guard < 200 && !(all_empty() && !out_valid)) begin
        selection = 2'd0;
        for (int p = NB - 1; p >= 0; p--) if (exp_q[p].size() != 0) selection = 2'(p);
        tick();
        guard++;
      end
      check_true("drain_done", guard < 200);
    end
    check("bursts_checked", bursts_checked, 6);

    // Reset with buffered and in-flight words
    selection = 2'd0; out_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      in_valid = 4'b0001; in_data[0] = 32'hF0 + 32'(i);
      tick();
    end
    in_valid = '0;
    check("pre_rst_valid", out_valid, 1);
    check("pre_rst_data", out_data, 32'hF0);
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_valid", out_valid, 0);
    check("async_rst_data", out_data, 0);
    check("async_rst_ready", in_ready, 4'hF);
    tick();
    rst_n = 1'b1;
    out_ready = 1'b1;
    repeat (4) begin
      tick();
      check("post_rst_quiet", out_valid, 0);
    end
    check_true("post_rst_sb_empty", all_empty());

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
